aclk_load_arbiter: RTL and testbench

- Arbitrates set-time and set-alarm requests from two requesters (keypad front-end `kp`, time-sync unit `sy`) onto the alarm clock's single configuration port: `H_in1/H_in0/M_in1/M_in0`, `LD_time`, `LD_alarm`.
- Validates BCD digits, sequences setup and a one-cycle load strobe, and returns done/error per requester.
- Sits between the requesters and the alarm clock core, in the core's clock domain.

---
 rtl/aclk_load_arbiter_if.sv | 36 +++
 rtl/aclk_load_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_aclk_load_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aclk_load_arbiter_if.sv
// Groups both requester handshakes, the core configuration port and the core readback.
// master = requester/core side, slave = the arbiter.
interface aclk_load_arbiter_if;
  logic       kp_valid, kp_ready, kp_alarm, kp_done, kp_err;
  logic [1:0] kp_h1;
  logic [3:0] kp_h0, kp_m1, kp_m0;

  logic       sy_valid, sy_ready, sy_alarm, sy_done, sy_err;
  logic [1:0] sy_h1;
  logic [3:0] sy_h0, sy_m1, sy_m0;

  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm;

  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0;

  logic       busy;

  modport master (
    output kp_valid, kp_alarm, kp_h1, kp_h0, kp_m1, kp_m0,
    output sy_valid, sy_alarm, sy_h1, sy_h0, sy_m1, sy_m0,
    output H_out1, H_out0, M_out1, M_out0,
    input  kp_ready, kp_done, kp_err, sy_ready, sy_done, sy_err,
    input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, busy
  );

  modport slave (
    input  kp_valid, kp_alarm, kp_h1, kp_h0, kp_m1, kp_m0,
    input  sy_valid, sy_alarm, sy_h1, sy_h0, sy_m1, sy_m0,
    input  H_out1, H_out0, M_out1, M_out0,
    output kp_ready, kp_done, kp_err, sy_ready, sy_done, sy_err,
    output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, busy
  );
endinterface

// File: rtl/aclk_load_arbiter.sv
// Round-robin arbiter loading validated BCD time/alarm settings into the alarm clock core.
// Define ACLK_ARB_VERIFY_EN to read back time loads from the core before reporting done.
module aclk_load_arbiter #(
  parameter int unsigned VERIFY_TIMEOUT = 20
) (
  input logic                clk,
  input logic                reset_n,
  aclk_load_arbiter_if.slave bus
);

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } digits_t;

  typedef struct packed {
    logic    alarm;
    digits_t dig;
  } payload_t;

`ifdef ACLK_ARB_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_CHECK, S_SETUP, S_LOAD, S_VERIFY, S_DONE
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_CHECK, S_SETUP, S_LOAD, S_DONE
  } state_e;
`endif

  if (VERIFY_TIMEOUT < 1 || VERIFY_TIMEOUT > 255) begin : g_bad_timeout
    $error("VERIFY_TIMEOUT must lie in 1..255");
  end

  state_e   state_q, state_d;
  logic     owner_q, owner_d;     // 1 = sy is the current requester
  logic     prio_sy_q, prio_sy_d; // 1 = sy wins the next tie
  payload_t pay_q, pay_d;
  digits_t  dig_q, dig_d;
  logic     kp_ready_q, kp_ready_d, sy_ready_q, sy_ready_d;
  logic     kp_done_q, kp_done_d, sy_done_q, sy_done_d;
  logic     kp_err_q, kp_err_d, sy_err_q, sy_err_d;
  logic     ld_time_q, ld_time_d, ld_alarm_q, ld_alarm_d;
  logic     busy_q, busy_d;
  logic     finish, fail, pick_sy;
`ifdef ACLK_ARB_VERIFY_EN
  logic [7:0] vcnt_q, vcnt_d;
`endif

  function automatic logic digits_legal(input digits_t d);
    return (d.h1 <= 2'd2) && (d.h0 <= 4'd9) && !(d.h1 == 2'd2 && d.h0 > 4'd3) &&
           (d.m1 <= 4'd5) && (d.m0 <= 4'd9);
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d    = state_q;
    owner_d    = owner_q;
    prio_sy_d  = prio_sy_q;
    pay_d      = pay_q;
    dig_d      = dig_q;
    kp_ready_d = 1'b0;
    sy_ready_d = 1'b0;
    ld_time_d  = 1'b0;
    ld_alarm_d = 1'b0;
    finish     = 1'b0;
    fail       = 1'b0;
    pick_sy    = 1'b0;
`ifdef ACLK_ARB_VERIFY_EN
    vcnt_d     = vcnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.kp_valid || bus.sy_valid) begin
          pick_sy    = bus.sy_valid && (!bus.kp_valid || prio_sy_q);
          owner_d    = pick_sy;
          prio_sy_d  = !pick_sy;
          kp_ready_d = !pick_sy;
          sy_ready_d = pick_sy;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        pay_d   = owner_q ? {bus.sy_alarm, bus.sy_h1, bus.sy_h0, bus.sy_m1, bus.sy_m0}
                          : {bus.kp_alarm, bus.kp_h1, bus.kp_h0, bus.kp_m1, bus.kp_m0};
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (digits_legal(pay_q.dig)) begin
          dig_d   = pay_q.dig;
          state_d = S_SETUP;
        end else begin
          finish  = 1'b1;
          fail    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_SETUP: begin
        ld_alarm_d = pay_q.alarm;
        ld_time_d  = !pay_q.alarm;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
`ifdef ACLK_ARB_VERIFY_EN
        if (!pay_q.alarm) begin
          vcnt_d  = '0;
          state_d = S_VERIFY;
        end else begin
          finish  = 1'b1;
          state_d = S_DONE;
        end
`else
        finish  = 1'b1;
        state_d = S_DONE;
`endif
      end
`ifdef ACLK_ARB_VERIFY_EN
      S_VERIFY: begin
        if ({bus.H_out1, bus.H_out0, bus.M_out1, bus.M_out0} == pay_q.dig) begin
          finish  = 1'b1;
          state_d = S_DONE;
        end else if (vcnt_q == 8'(VERIFY_TIMEOUT - 1)) begin
          finish  = 1'b1;
          fail    = 1'b1;
          state_d = S_DONE;
        end else begin
          vcnt_d = vcnt_q + 8'd1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are computed one state ahead so the registered values line up with the state.
    kp_done_d = finish && !owner_q;
    sy_done_d = finish && owner_q;
    kp_err_d  = finish && fail && !owner_q;
    sy_err_d  = finish && fail && owner_q;
    busy_d    = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      prio_sy_q  <= 1'b0;
      pay_q      <= '0;
      dig_q      <= '0;
      kp_ready_q <= 1'b0;
      sy_ready_q <= 1'b0;
      kp_done_q  <= 1'b0;
      sy_done_q  <= 1'b0;
      kp_err_q   <= 1'b0;
      sy_err_q   <= 1'b0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ACLK_ARB_VERIFY_EN
      vcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      prio_sy_q  <= prio_sy_d;
      pay_q      <= pay_d;
      dig_q      <= dig_d;
      kp_ready_q <= kp_ready_d;
      sy_ready_q <= sy_ready_d;
      kp_done_q  <= kp_done_d;
      sy_done_q  <= sy_done_d;
      kp_err_q   <= kp_err_d;
      sy_err_q   <= sy_err_d;
      ld_time_q  <= ld_time_d;
      ld_alarm_q <= ld_alarm_d;
      busy_q     <= busy_d;
`ifdef ACLK_ARB_VERIFY_EN
      vcnt_q     <= vcnt_d;
`endif
    end
  end

  assign bus.kp_ready = kp_ready_q;
  assign bus.sy_ready = sy_ready_q;
  assign bus.kp_done  = kp_done_q;
  assign bus.sy_done  = sy_done_q;
  assign bus.kp_err   = kp_err_q;
  assign bus.sy_err   = sy_err_q;
  assign bus.H_in1    = dig_q.h1;
  assign bus.H_in0    = dig_q.h0;
  assign bus.M_in1    = dig_q.m1;
  assign bus.M_in0    = dig_q.m0;
  assign bus.LD_time  = ld_time_q;
  assign bus.LD_alarm = ld_alarm_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_aclk_load_arbiter.sv
// Scoreboard bench for aclk_load_arbiter: stimulus pushes predicted transactions,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_aclk_load_arbiter;
  localparam int unsigned T = 20;
`ifdef ACLK_ARB_VERIFY_EN
  localparam int LOSER_MAX = 8;
`else
  localparam int LOSER_MAX = 7;
`endif

  typedef struct {
    bit       alarm;
    bit [1:0] h1;
    bit [3:0] h0, m1, m0;
  } req_t;

  typedef struct {
    bit        who;       // 1 = sy
    bit        legal;
    bit        err;
    bit        alarm;
    bit [13:0] dig;
    bit [13:0] dig_after; // core digit outputs expected once this request completes
    int        lat;       // done cycle minus ready cycle
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  aclk_load_arbiter_if bus();
  aclk_load_arbiter #(.VERIFY_TIMEOUT(T)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  int        ready_cyc = 0;
  int        done_seen = 0;
  bit        last_sy = 1'b1;
  bit        echo = 1'b0;
  bit [13:0] model_dig = '0;
  bit        exp_ready_q[$];
  exp_t      txn_q[$];
  exp_t      cur;
  exp_t      mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Core readback: either echoes the loaded digits or stays stuck at 00:00.
  always_comb begin
    if (echo) begin
      bus.H_out1 = bus.H_in1;
      bus.H_out0 = bus.H_in0;
      bus.M_out1 = bus.M_in1;
      bus.M_out0 = bus.M_in0;
    end else begin
      bus.H_out1 = '0;
      bus.H_out0 = '0;
      bus.M_out1 = '0;
      bus.M_out0 = '0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit [13:0] dig_of(input req_t r);
    return {r.h1, r.h0, r.m1, r.m0};
  endfunction

  function automatic logic [13:0] dut_dig();
    return {bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0};
  endfunction

  function automatic logic [22:0] all_outputs();
    return {bus.kp_ready, bus.sy_ready, bus.kp_done, bus.sy_done, bus.kp_err, bus.sy_err,
            dut_dig(), bus.LD_time, bus.LD_alarm, bus.busy};
  endfunction

  // A setting is loadable when every digit is decimal and it names a real time of day.
  function automatic bit is_legal(input req_t r);
    int hours = int'(r.h1) * 10 + int'(r.h0);
    int mins  = int'(r.m1) * 10 + int'(r.m0);
    return r.h0 <= 9 && r.m1 <= 9 && r.m0 <= 9 && hours < 24 && mins < 60;
  endfunction

  function automatic req_t mk(input bit alarm, input int h1, input int h0, input int m1, input int m0);
    req_t r;
    r.alarm = alarm;
    r.h1 = 2'(h1);
    r.h0 = 4'(h0);
    r.m1 = 4'(m1);
    r.m0 = 4'(m0);
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.alarm = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) != 0) begin
      r.h1 = 2'($urandom_range(0, 2));
      r.h0 = 4'($urandom_range(0, (r.h1 == 2'd2) ? 3 : 9));
      r.m1 = 4'($urandom_range(0, 5));
      r.m0 = 4'($urandom_range(0, 9));
    end else begin
      r.h1 = 2'($urandom);
      r.h0 = 4'($urandom);
      r.m1 = 4'($urandom);
      r.m0 = 4'($urandom);
    end
    return r;
  endfunction

  function automatic exp_t make_item(input bit who, input req_t r);
    exp_t e;
    bit   vfail;
    e.who   = who;
    e.legal = is_legal(r);
    e.alarm = r.alarm;
    e.dig   = dig_of(r);
    if (e.legal) model_dig = e.dig;
    e.dig_after = model_dig;
`ifdef ACLK_ARB_VERIFY_EN
    vfail = e.legal && !r.alarm && !(echo || e.dig == '0);
    e.err = !e.legal || vfail;
    e.lat = !e.legal ? 2 : (r.alarm ? 4 : (vfail ? 4 + int'(T) : 5));
`else
    vfail = 1'b0;
    e.err = !e.legal || vfail;
    e.lat = e.legal ? 4 : 2;
`endif
    return e;
  endfunction

  task automatic push(input bit who, input req_t r);
    exp_ready_q.push_back(who);
    txn_q.push_back(make_item(who, r));
  endtask

  task automatic drive(input bit who, input req_t r, input bit solo);
    int issue_cyc;
    bit got = 1'b0;
    if (who) begin
      {bus.sy_alarm, bus.sy_h1, bus.sy_h0, bus.sy_m1, bus.sy_m0} = {r.alarm, r.h1, r.h0, r.m1, r.m0};
      bus.sy_valid = 1'b1;
    end else begin
      {bus.kp_alarm, bus.kp_h1, bus.kp_h0, bus.kp_m1, bus.kp_m0} = {r.alarm, r.h1, r.h0, r.m1, r.m0};
      bus.kp_valid = 1'b1;
    end
    issue_cyc = cyc;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (who ? bus.sy_ready : bus.kp_ready) got = 1'b1;
    end
    if (!got) check(who ? "sy_ready_timeout" : "kp_ready_timeout", 0, 1);
    else if (solo) check("ready_latency", cyc - issue_cyc, 1);
    else check("loser_latency_bound", (cyc - issue_cyc) <= LOSER_MAX, 1);
    @(posedge clk);
    #1;
    if (who) bus.sy_valid = 1'b0;
    else bus.kp_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((txn_q.size() != 0 || bus.busy) && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("quiet_timeout", n < 80, 1);
  endtask

  // Predicts grant order from the round-robin rule, then drives the request(s).
  task automatic issue(input bit use_kp, input bit use_sy, input req_t kr, input req_t sr, input bit settle);
    bit first_sy;
    @(negedge clk);
    if (use_kp && use_sy) begin
      first_sy = !last_sy;
      push(first_sy, first_sy ? sr : kr);
      push(!first_sy, first_sy ? kr : sr);
      last_sy = !first_sy;
    end else if (use_kp) begin
      push(1'b0, kr);
      last_sy = 1'b0;
    end else begin
      push(1'b1, sr);
      last_sy = 1'b1;
    end
    fork
      begin if (use_kp) drive(1'b0, kr, !use_sy); end
      begin if (use_sy) drive(1'b1, sr, !use_kp); end
    join
    if (settle) wait_quiet();
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.kp_ready || bus.sy_ready) begin
        check("single_ready", bus.kp_ready && bus.sy_ready, 0);
        check("ready_expected", exp_ready_q.size() != 0, 1);
        if (exp_ready_q.size() != 0) check("ready_who", bus.sy_ready, exp_ready_q.pop_front());
        check("busy_in_grant", bus.busy, 1);
        ready_cyc = cyc;
        if (txn_q.size() != 0) cur = txn_q[0];
      end
      if (bus.LD_time || bus.LD_alarm) begin
        check("single_strobe", bus.LD_time && bus.LD_alarm, 0);
        check("ld_cycle", cyc - ready_cyc, 3);
        check("ld_only_if_legal", cur.legal, 1);
        check("ld_kind_alarm", bus.LD_alarm, cur.alarm);
        check("ld_digits", dut_dig(), cur.dig);
      end
      if (bus.kp_done || bus.sy_done) begin
        done_seen++;
        check("single_done", bus.kp_done && bus.sy_done, 0);
        check("done_expected", txn_q.size() != 0, 1);
        if (txn_q.size() != 0) begin
          mon_e = txn_q.pop_front();
          check("done_who", bus.sy_done, mon_e.who);
          check("done_err", bus.kp_err || bus.sy_err, mon_e.err);
          check("done_latency", cyc - ready_cyc, mon_e.lat);
          check("digits_after", dut_dig(), mon_e.dig_after);
          check("busy_in_done", bus.busy, 1);
        end
      end else begin
        check("err_without_done", bus.kp_err || bus.sy_err, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    int d0;
    int n;
    bus.kp_valid = 1'b0; bus.kp_alarm = 1'b0;
    bus.kp_h1 = '0; bus.kp_h0 = '0; bus.kp_m1 = '0; bus.kp_m0 = '0;
    bus.sy_valid = 1'b0; bus.sy_alarm = 1'b0;
    bus.sy_h1 = '0; bus.sy_h0 = '0; bus.sy_m1 = '0; bus.sy_m0 = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), '0);
    reset_n = 1'b1;
    echo = 1'b1;

    issue(1'b1, 1'b0, mk(0, 2, 3, 5, 9), mk(0, 0, 0, 0, 0), 1'b1);   // kp time 23:59
    issue(1'b0, 1'b1, mk(0, 0, 0, 0, 0), mk(1, 2, 4, 0, 0), 1'b1);   // sy alarm 24:00 rejected
    issue(1'b1, 1'b1, mk(0, 0, 1, 0, 2), mk(1, 1, 3, 4, 5), 1'b1);   // tie
    issue(1'b1, 1'b1, mk(1, 2, 2, 2, 2), mk(0, 0, 9, 5, 9), 1'b1);   // tie again

    // Reset asserted during LOAD of a 07:30 time request.
    issue(1'b1, 1'b0, mk(0, 0, 7, 3, 0), mk(0, 0, 0, 0, 0), 1'b0);
    n = 0;
    while (!bus.LD_time && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("reset_test_saw_load", bus.LD_time, 1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset_drops_ld", bus.LD_time, 0);
    check("reset_mid_outputs", all_outputs(), '0);
    txn_q.delete();
    exp_ready_q.delete();
    model_dig = '0;
    last_sy = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    d0 = done_seen;
    repeat (8) @(negedge clk);
    check("no_done_after_reset", done_seen - d0, 0);

    issue(1'b1, 1'b1, mk(1, 0, 6, 1, 5), mk(0, 1, 8, 0, 0), 1'b1);   // first tie after reset

`ifdef ACLK_ARB_VERIFY_EN
    echo = 1'b0;
    issue(1'b1, 1'b0, mk(0, 1, 2, 3, 4), mk(0, 0, 0, 0, 0), 1'b1);   // readback stuck at 00:00
    echo = 1'b1;
    issue(1'b1, 1'b0, mk(0, 1, 2, 3, 4), mk(0, 0, 0, 0, 0), 1'b1);   // readback echoes 12:34
`endif

    for (int i = 0; i < 40; i++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      issue(mode != 1, mode != 0, rand_req(), rand_req(), 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
